// File: rtl/al_set_control_pkg.sv
// Shared alarm-set types and constants: FSM state encoding, field indices, time limits.
package al_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    // Bit positions of each field inside the one-hot target select.
    localparam int FIELD_H = 2;
    localparam int FIELD_M = 1;
    localparam int FIELD_S = 0;

    localparam logic [6:0] HOUR_MAX   = 7'd23;
    localparam logic [6:0] MINSEC_MAX = 7'd59;

    // The external hour counter wraps at 59; fold it into 0..23, treating an
    // out-of-range value reached from 0 as a decrement wrap.
    function automatic logic [6:0] fold_hour(input logic [6:0] cnt, input logic [6:0] prev);
        logic [6:0] res;
        res = cnt;
        if (cnt > HOUR_MAX) begin
            res = (prev == 7'd0) ? HOUR_MAX : 7'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/al_set_control_ring_timer.sv
// Loadable down-counter shared by the ring duration and the snooze delay.
module al_ring_timer #(
    parameter int W = 18
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         count_en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count_en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/al_set_control.sv
// Alarm set/arm/ring controller. Optional snooze on BTN_INC is enabled by `define AL_SNOOZE_EN.
module al_set_control
    import al_pkg::*;
#(
    parameter int RING_CYCLES   = 250000,
    parameter int SNOOZE_CYCLES = 500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_SET,
    input  logic       BTN_INC,
    input  logic [6:0] CNT_H,
    input  logic [6:0] CNT_M,
    input  logic [6:0] CNT_S,
    input  logic [6:0] CUR_H,
    input  logic [6:0] CUR_M,
    input  logic [6:0] CUR_S,
    output logic       SET_FLAG,
    output logic [2:0] TGT,
    output logic       PREV_SET,
    output logic [6:0] AL_H,
    output logic [6:0] AL_M,
    output logic [6:0] AL_S,
    output logic       ARMED,
    output logic       RING,
    output state_t     STATE
);

    localparam int TMAX = (RING_CYCLES > SNOOZE_CYCLES) ? RING_CYCLES : SNOOZE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t        state, state_next;
    logic          set_rise, cur_eq_al, match, match_hold;
    logic          timer_load, timer_en, timer_zero;
    logic [TW-1:0] timer_val;
    logic          snoozing, snooze_start, snooze_expire;

    assign set_rise  = BTN_SET & ~PREV_SET;
    assign cur_eq_al = (CUR_H == AL_H) && (CUR_M == AL_M) && (CUR_S == AL_S);
    // A SET rise wins over a coincident match, so it suppresses the ring here.
    assign match = (state == IDLE) && ARMED && !RING && !snoozing && !match_hold
                   && cur_eq_al && !set_rise;

`ifdef AL_SNOOZE_EN
    logic prev_inc, inc_rise;
    assign inc_rise      = BTN_INC & ~prev_inc;
    assign snooze_start  = RING & inc_rise & ~set_rise;
    assign snooze_expire = snoozing & timer_zero & ~set_rise;

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_inc <= 1'b0;
            snoozing <= 1'b0;
        end else begin
            prev_inc <= BTN_INC;
            if (snooze_start) begin
                snoozing <= 1'b1;
            end else if (snooze_expire || (snoozing && set_rise)) begin
                snoozing <= 1'b0;
            end
        end
    end
`else
    logic unused_inc;
    assign unused_inc    = BTN_INC;
    assign snoozing      = 1'b0;
    assign snooze_start  = 1'b0;
    assign snooze_expire = 1'b0;
`endif

    assign timer_load = match | snooze_start | snooze_expire;
    assign timer_val  = snooze_start ? TW'(SNOOZE_CYCLES - 1) : TW'(RING_CYCLES - 1);
    assign timer_en   = RING | snoozing;

    al_ring_timer #(.W(TW)) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (timer_load),
        .load_val (timer_val),
        .count_en (timer_en),
        .zero     (timer_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        TGT        = 3'b000;
        SET_FLAG   = (state != IDLE);
        case (state)
            IDLE: begin
                if (set_rise && !RING) state_next = SET_H;
            end
            SET_H: begin
                TGT[FIELD_H] = 1'b1;
                if (set_rise) state_next = SET_M;
            end
            SET_M: begin
                TGT[FIELD_M] = 1'b1;
                if (set_rise) state_next = SET_S;
            end
            SET_S: begin
                TGT[FIELD_S] = 1'b1;
                if (set_rise) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            PREV_SET   <= 1'b0;
            AL_H       <= '0;
            AL_M       <= '0;
            AL_S       <= '0;
            ARMED      <= 1'b0;
            RING       <= 1'b0;
            match_hold <= 1'b0;
        end else begin
            PREV_SET <= BTN_SET;
            case (state)
                IDLE: begin
                    if (set_rise && !RING) begin
                        AL_H  <= '0;
                        AL_M  <= '0;
                        AL_S  <= '0;
                        ARMED <= 1'b0;
                    end
                end
                SET_H: AL_H <= fold_hour(CNT_H, AL_H);
                SET_M: AL_M <= CNT_M;
                SET_S: begin
                    AL_S <= CNT_S;
                    if (set_rise) ARMED <= 1'b1;
                end
                default: ;
            endcase
            if (RING && (set_rise || snooze_start || timer_zero)) begin
                RING <= 1'b0;
            end else if (match || snooze_expire) begin
                RING <= 1'b1;
            end
            // One ring per matched second: hold until the seconds move on.
            if (match) begin
                match_hold <= 1'b1;
            end else if (CUR_S != AL_S) begin
                match_hold <= 1'b0;
            end
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_al_set_control.sv
// Directed bench for al_set_control; snooze vectors run when AL_SNOOZE_EN is defined.
module tb_al_set_control;
    import al_pkg::*;

    localparam int RING_N   = 6;
    localparam int SNOOZE_N = 10;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BTN_SET = 1'b0;
    logic       BTN_INC = 1'b0;
    logic [6:0] CNT_H = '0, CNT_M = '0, CNT_S = '0;
    logic [6:0] CUR_H = '0, CUR_M = '0, CUR_S = '0;
    logic       SET_FLAG, PREV_SET, ARMED, RING;
    logic [2:0] TGT;
    logic [6:0] AL_H, AL_M, AL_S;
    state_t     STATE;

    int n_checks = 0;
    int n_pass   = 0;
    int ring_cnt;
    int ring_at;

    al_set_control #(.RING_CYCLES(RING_N), .SNOOZE_CYCLES(SNOOZE_N)) dut (
        .CLK(CLK), .RST(RST), .BTN_SET(BTN_SET), .BTN_INC(BTN_INC),
        .CNT_H(CNT_H), .CNT_M(CNT_M), .CNT_S(CNT_S),
        .CUR_H(CUR_H), .CUR_M(CUR_M), .CUR_S(CUR_S),
        .SET_FLAG(SET_FLAG), .TGT(TGT), .PREV_SET(PREV_SET),
        .AL_H(AL_H), .AL_M(AL_M), .AL_S(AL_S),
        .ARMED(ARMED), .RING(RING), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_pulse();
        BTN_SET = 1'b1;
        tick();
        BTN_SET = 1'b0;
        tick();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_state"}, 32'(STATE), 32'(IDLE));
        check({tag, "_set_flag"}, 32'(SET_FLAG), 0);
        check({tag, "_tgt"}, 32'(TGT), 0);
        check({tag, "_prev_set"}, 32'(PREV_SET), 0);
        check({tag, "_al"}, {11'd0, AL_H, AL_M, AL_S}, 0);
        check({tag, "_armed"}, 32'(ARMED), 0);
        check({tag, "_ring"}, 32'(RING), 0);
    endtask

    initial begin
        tick();
        tick();
        check_cleared("reset");
        RST = 1'b0;
        tick();

        // Walk the set sequence while programming 07:30:00.
        BTN_SET = 1'b1;
        tick();
        check("prev_set_hi", 32'(PREV_SET), 1);
        check("st_set_h", 32'(STATE), 32'(SET_H));
        check("tgt_h", 32'(TGT), 32'b100);
        check("set_flag_h", 32'(SET_FLAG), 1);
        BTN_SET = 1'b0;
        tick();
        CNT_H = 7'd59;
        tick();
        check("fold_59", 32'(AL_H), 23);
        CNT_H = 7'd24;
        tick();
        check("fold_24", 32'(AL_H), 0);
        CNT_H = 7'd7;
        tick();
        check("al_h_7", 32'(AL_H), 7);

        set_pulse();
        check("st_set_m", 32'(STATE), 32'(SET_M));
        check("tgt_m", 32'(TGT), 32'b010);
        tick();
        check("al_m_0", 32'(AL_M), 0);
        CNT_M = 7'd1;
        check("al_m_latency", 32'(AL_M), 0);
        tick();
        check("al_m_1", 32'(AL_M), 1);
        CNT_M = 7'd2;
        tick();
        check("al_m_2", 32'(AL_M), 2);
        check("al_h_hold", 32'(AL_H), 7);
        check("al_s_hold", 32'(AL_S), 0);
        CNT_M = 7'd30;
        tick();
        check("al_m_30", 32'(AL_M), 30);

        set_pulse();
        check("st_set_s", 32'(STATE), 32'(SET_S));
        check("tgt_s", 32'(TGT), 32'b001);
        tick();
        set_pulse();
        check("st_idle", 32'(STATE), 32'(IDLE));
        check("tgt_idle", 32'(TGT), 0);
        check("armed", 32'(ARMED), 1);
        check("alarm_07_30_00", {11'd0, AL_H, AL_M, AL_S}, {11'd0, 7'd7, 7'd30, 7'd0});

        // Match and ring duration.
        CUR_H = 7'd7; CUR_M = 7'd29; CUR_S = 7'd59;
        tick();
        check("no_ring_early", 32'(RING), 0);
        CUR_M = 7'd30; CUR_S = 7'd0;
        tick();
        check("ring_start", 32'(RING), 1);
        ring_cnt = 1;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (RING) ring_cnt++;
        end
        check("ring_len", 32'(ring_cnt), RING_N);

        // SET rise mid-ring only silences the alarm.
        CUR_S = 7'd1;
        tick();
        CUR_S = 7'd0;
        tick();
        check("ring_again", 32'(RING), 1);
        tick();
        tick();
        BTN_SET = 1'b1;
        tick();
        check("set_stops_ring", 32'(RING), 0);
        check("set_ring_state", 32'(STATE), 32'(IDLE));
        check("set_ring_armed", 32'(ARMED), 1);
        BTN_SET = 1'b0;
        tick();
        check("no_retrigger", 32'(RING), 0);

        // SET rise coincident with a match.
        CUR_S = 7'd1;
        tick();
        CUR_S = 7'd0;
        BTN_SET = 1'b1;
        tick();
        check("coinc_ring", 32'(RING), 0);
        check("coinc_state", 32'(STATE), 32'(SET_H));
        check("coinc_al", {11'd0, AL_H, AL_M, AL_S}, 0);
        check("coinc_armed", 32'(ARMED), 0);
        BTN_SET = 1'b0;
        CUR_S = 7'd5;
        tick();
        set_pulse();
        tick();
        set_pulse();
        tick();
        set_pulse();
        check("rearm", 32'(ARMED), 1);
        check("rearm_al", {11'd0, AL_H, AL_M, AL_S}, {11'd0, 7'd7, 7'd30, 7'd0});
        check("rearm_quiet", 32'(RING), 0);

        CUR_S = 7'd0;
        tick();
        check("ring3", 32'(RING), 1);
`ifdef AL_SNOOZE_EN
        tick();
        BTN_INC = 1'b1;
        tick();
        check("snooze_off", 32'(RING), 0);
        BTN_INC = 1'b0;
        ring_at = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (RING) begin
                ring_at = i;
                break;
            end
        end
        check("snooze_delay", 32'(ring_at), SNOOZE_N);
        BTN_INC = 1'b1;
        tick();
        check("snooze2_off", 32'(RING), 0);
        BTN_INC = 1'b0;
        tick();
        tick();
        tick();
`else
        BTN_INC = 1'b1;
        tick();
        check("inc_ignored", 32'(RING), 1);
        BTN_INC = 1'b0;
        tick();
`endif
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_cleared("mid_rst");
        ring_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (RING) ring_cnt++;
        end
        check("post_rst_quiet", 32'(ring_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
